// File: rtl/ps2_mouse_init_sequencer_if.sv
// Command/response bundle between the PS/2 mouse init sequencer and its
// surroundings (PS/2 controller, packet parser, system control).
interface ps2_mouse_init_sequencer_if;
  logic       start;
  logic [7:0] ps2_received_data;
  logic       ps2_received_data_en;
  logic       command_was_sent;
  logic       error_communication_timed_out;
  logic [7:0] the_command;
  logic       send_command;
  logic       stream_enable;
  logic       busy;
  logic       init_done;
  logic       init_error;

  modport master (
    input  start, ps2_received_data, ps2_received_data_en,
           command_was_sent, error_communication_timed_out,
    output the_command, send_command, stream_enable, busy, init_done, init_error
  );

  modport slave (
    output start, ps2_received_data, ps2_received_data_en,
           command_was_sent, error_communication_timed_out,
    input  the_command, send_command, stream_enable, busy, init_done, init_error
  );
endinterface

// File: rtl/ps2_mouse_init_sequencer.sv
// Resets and configures a PS/2 mouse (FF, F3 rate, E8 res, F4), checking every
// response; gates the parser via stream_enable until configuration succeeds.
module ps2_mouse_init_sequencer #(
  parameter logic [7:0]  SAMPLE_RATE  = 8'd100,
  parameter logic [7:0]  RESOLUTION   = 8'd2,
  parameter logic [25:0] RESP_TIMEOUT = 26'd25_000_000,
  parameter logic [1:0]  MAX_RETRIES  = 2'd3
) (
  input  logic                         CLOCK_50,
  input  logic                         reset,
  ps2_mouse_init_sequencer_if.master   bus
);

  typedef enum logic [2:0] {
    IDLE, SEND, WAIT_SENT, WAIT_ACK, WAIT_BAT, WAIT_ID, DONE, FAIL
  } state_e;

  state_e      state_q;
  logic [2:0]  step_q;
  logic [1:0]  retry_q;
  logic [2:0]  resend_q;
  logic [25:0] timer_q;
  logic [25:0] timer_d;
  logic [7:0]  cmd_q;
  logic        send_q, stream_q, busy_q, done_q, error_q;
  logic [7:0]  table_byte;
  logic        timeout;
  logic        retry_take;
  logic        rx_en;
  logic [7:0]  rx_byte;

  assign rx_en   = bus.ps2_received_data_en;
  assign rx_byte = bus.ps2_received_data;
  assign timer_d = (timer_q == '1) ? timer_q : timer_q + 26'd1;
  assign timeout = (timer_q == RESP_TIMEOUT - 26'd1);

  always_comb begin
    case (step_q)
      3'd0:    table_byte = 8'hFF;
      3'd1:    table_byte = 8'hF3;
      3'd2:    table_byte = SAMPLE_RATE;
      3'd3:    table_byte = 8'hE8;
      3'd4:    table_byte = RESOLUTION;
      default: table_byte = 8'hF4;
    endcase
  end

  // Every failure cause funnels into one restart decision; a strobe in the
  // last timer cycle is judged on its byte and pre-empts the timeout.
  always_comb begin
    retry_take = 1'b0;
    case (state_q)
      WAIT_SENT: retry_take = bus.error_communication_timed_out;
      WAIT_ACK:  retry_take = rx_en ? !(rx_byte == 8'hFA ||
                                        (rx_byte == 8'hFE && resend_q != 3'd4))
                                    : timeout;
      WAIT_BAT:  retry_take = rx_en ? (rx_byte != 8'hAA) : timeout;
      WAIT_ID:   retry_take = rx_en ? (rx_byte != 8'h00) : timeout;
      default:   retry_take = 1'b0;
    endcase
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      step_q   <= '0;
      retry_q  <= '0;
      resend_q <= '0;
      timer_q  <= '0;
      cmd_q    <= '0;
      send_q   <= 1'b0;
      stream_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      busy_q   <= !(state_q inside {IDLE, DONE, FAIL});
      done_q   <= (state_q == DONE);
      stream_q <= (state_q == DONE);
      error_q  <= (state_q == FAIL);
      if (state_q inside {WAIT_ACK, WAIT_BAT, WAIT_ID}) timer_q <= timer_d;

      if (retry_take) begin
        send_q   <= 1'b0;
        resend_q <= '0;
        if (retry_q == MAX_RETRIES) begin
          state_q <= FAIL;
        end else begin
          retry_q <= retry_q + 2'd1;
          step_q  <= '0;
          state_q <= SEND;
        end
      end else begin
        case (state_q)
          IDLE, DONE, FAIL: begin
            if (bus.start) begin
              step_q   <= '0;
              retry_q  <= '0;
              resend_q <= '0;
              state_q  <= SEND;
            end
          end
          SEND: begin
            cmd_q   <= table_byte;
            send_q  <= 1'b1;
            state_q <= WAIT_SENT;
          end
          WAIT_SENT: begin
            if (bus.command_was_sent) begin
              send_q  <= 1'b0;
              timer_q <= '0;
              state_q <= WAIT_ACK;
            end
          end
          WAIT_ACK: begin
            if (rx_en) begin
              if (rx_byte == 8'hFE) begin
                resend_q <= resend_q + 3'd1;
                state_q  <= SEND;
              end else begin
                resend_q <= '0;
                if (step_q == 3'd0) begin
                  timer_q <= '0;
                  state_q <= WAIT_BAT;
                end else if (step_q == 3'd5) begin
                  state_q <= DONE;
                end else begin
                  step_q  <= step_q + 3'd1;
                  state_q <= SEND;
                end
              end
            end
          end
          WAIT_BAT: begin
            if (rx_en) begin
              timer_q <= '0;
              state_q <= WAIT_ID;
            end
          end
          WAIT_ID: begin
            if (rx_en) begin
              step_q  <= 3'd1;
              state_q <= SEND;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign bus.the_command   = cmd_q;
  assign bus.send_command  = send_q;
  assign bus.stream_enable = stream_q;
  assign bus.busy          = busy_q;
  assign bus.init_done     = done_q;
  assign bus.init_error    = error_q;

endmodule

// File: tb/tb_ps2_mouse_init_sequencer.sv
// Self-checking bench for ps2_mouse_init_sequencer: vector table, directed
// corner sequences and randomized runs against a transaction-level model.
module tb_ps2_mouse_init_sequencer;

  localparam int K_SEND  = 0;
  localparam int K_QUIET = 1;
  localparam int K_DONE  = 2;

  typedef struct {
    int         pos;   // 0 FF-ack, 1 BAT, 2 ID, 3..7 ack of F3,64,E8,02,F4
    logic [7:0] rsp;
    int         kind;
    logic [7:0] exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ps2_mouse_init_sequencer_if bus();

  ps2_mouse_init_sequencer #(
    .SAMPLE_RATE (8'd100),
    .RESOLUTION  (8'd2),
    .RESP_TIMEOUT(26'd100),
    .MAX_RETRIES (2'd3)
  ) dut (
    .CLOCK_50(clk),
    .reset   (rst),
    .bus     (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0] cmd_bytes [6] = '{8'hFF, 8'hF3, 8'd100, 8'hE8, 8'd2, 8'hF4};
  vec_t vt [17];

  int m_step, m_retry, m_resends;
  bit m_done, m_failed;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic idle_inputs();
    bus.start                         = 1'b0;
    bus.ps2_received_data             = 8'h00;
    bus.ps2_received_data_en          = 1'b0;
    bus.command_was_sent              = 1'b0;
    bus.error_communication_timed_out = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_inputs();
    tick(2);
    rst = 1'b0;
    tick();
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic wait_send(input string name, input logic [7:0] exp, input int limit);
    int i = 0;
    while (!bus.send_command && i < limit) begin
      tick();
      i++;
    end
    check({name, " send_command"}, bus.send_command, 1);
    check({name, " the_command"}, bus.the_command, exp);
  endtask

  task automatic do_sent();
    bus.command_was_sent = 1'b1;
    tick();
    bus.command_was_sent = 1'b0;
  endtask

  task automatic reply(input logic [7:0] b);
    bus.ps2_received_data    = b;
    bus.ps2_received_data_en = 1'b1;
    tick();
    bus.ps2_received_data_en = 1'b0;
  endtask

  task automatic check_all_zero(input string name);
    check({name, " the_command"},   bus.the_command, 0);
    check({name, " send_command"},  bus.send_command, 0);
    check({name, " stream_enable"}, bus.stream_enable, 0);
    check({name, " busy"},          bus.busy, 0);
    check({name, " init_done"},     bus.init_done, 0);
    check({name, " init_error"},    bus.init_error, 0);
  endtask

  // Start and complete steps 0..s-1 with good replies; leaves step s pending.
  task automatic prefix_to(input int s);
    pulse_start();
    for (int k = 0; k < s; k++) begin
      wait_send("prefix", cmd_bytes[k], 20);
      do_sent();
      reply(8'hFA);
      if (k == 0) begin
        reply(8'hAA);
        reply(8'h00);
      end
    end
    wait_send("prefix", cmd_bytes[s], 20);
  endtask

  task automatic run_happy(input string tag);
    prefix_to(5);
    do_sent();
    reply(8'hFA);
    check({tag, " init_done one cycle after FA"}, bus.init_done, 0);
    tick();
    check({tag, " init_done"},     bus.init_done, 1);
    check({tag, " stream_enable"}, bus.stream_enable, 1);
    check({tag, " busy"},          bus.busy, 0);
    check({tag, " init_error"},    bus.init_error, 0);
  endtask

  // Good replies up to position p; the reply at position p is 'last'.
  task automatic walk_to(input int p, input logic [7:0] last);
    logic [7:0] b;
    for (int q = 0; q <= p; q++) begin
      if (q == 0 || q >= 3) begin
        wait_send("walk", cmd_bytes[(q == 0) ? 0 : q - 2], 20);
        do_sent();
      end
      b = (q == 1) ? 8'hAA : (q == 2) ? 8'h00 : 8'hFA;
      reply((q == p) ? last : b);
    end
  endtask

  // FF is pending on entry; fail its BAT 'resent' times (FF must come back
  // each time), then once more, which must land in the error state.
  task automatic bad_bat_rounds(input string tag, input int resent);
    for (int r = 0; r <= resent; r++) begin
      wait_send(tag, 8'hFF, 20);
      do_sent();
      reply(8'hFA);
      reply(8'hFC);
    end
    tick();
    check({tag, " init_error"},    bus.init_error, 1);
    check({tag, " busy"},          bus.busy, 0);
    check({tag, " stream_enable"}, bus.stream_enable, 0);
    check({tag, " init_done"},     bus.init_done, 0);
  endtask

  task automatic model_retry();
    m_resends = 0;
    if (m_retry == 3) m_failed = 1'b1;
    else begin
      m_retry++;
      m_step = 0;
    end
  endtask

  // Replies 'good' most of the time, otherwise a wrong byte or silence.
  task automatic answer(input logic [7:0] good, output bit ok);
    int r;
    tick($urandom_range(0, 3));
    r = $urandom_range(0, 99);
    ok = 1'b0;
    if (r < 85) begin
      reply(good);
      ok = 1'b1;
    end else if (r < 93) begin
      reply(8'($urandom_range(1, 160)));
    end
  endtask

  task automatic random_run(input int run);
    int r;
    int guard = 0;
    bit ok;
    string tag = $sformatf("rand%0d", run);
    m_step = 0; m_retry = 0; m_resends = 0; m_done = 1'b0; m_failed = 1'b0;
    do_reset();
    pulse_start();
    while (!m_done && !m_failed && guard < 400) begin
      guard++;
      wait_send(tag, cmd_bytes[m_step], 150);
      if (!bus.send_command) break;
      tick($urandom_range(0, 2));
      if ($urandom_range(0, 15) == 0) begin
        bus.error_communication_timed_out = 1'b1;
        bus.command_was_sent = 1'($urandom_range(0, 1));
        tick();
        bus.error_communication_timed_out = 1'b0;
        bus.command_was_sent = 1'b0;
        model_retry();
      end else begin
        do_sent();
        tick($urandom_range(0, 3));
        r = $urandom_range(0, 99);
        if (r < 70) begin
          reply(8'hFA);
          m_resends = 0;
          if (m_step == 5) m_done = 1'b1;
          else if (m_step > 0) m_step++;
          else begin
            answer(8'hAA, ok);
            if (ok) answer(8'h00, ok);
            if (ok) m_step = 1;
            else model_retry();
          end
        end else if (r < 82) begin
          reply(8'hFE);
          m_resends++;
          if (m_resends == 5) model_retry();
        end else if (r < 92) begin
          reply(8'($urandom_range(1, 160)));
          model_retry();
        end else begin
          model_retry();
        end
      end
    end
    if (m_done || m_failed) begin
      for (int i = 0; i < 150 && !(bus.init_done || bus.init_error); i++) tick();
      check({tag, " init_done"},     bus.init_done, 32'(m_done));
      check({tag, " init_error"},    bus.init_error, 32'(m_failed));
      check({tag, " stream_enable"}, bus.stream_enable, 32'(m_done));
      check({tag, " busy"},          bus.busy, 0);
    end
  endtask

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation exceeded 90000 cycles without reaching summary");
    $fatal(1);
  end

  initial begin
    int n;
    bit seen;
    vt = '{
      '{0, 8'hFE, K_SEND,  8'hFF}, '{0, 8'hFA, K_QUIET, 8'h00},
      '{0, 8'h11, K_SEND,  8'hFF}, '{1, 8'hAA, K_QUIET, 8'h00},
      '{1, 8'hFC, K_SEND,  8'hFF}, '{2, 8'h00, K_SEND,  8'hF3},
      '{2, 8'hAA, K_SEND,  8'hFF}, '{3, 8'hFA, K_SEND,  8'h64},
      '{3, 8'hFE, K_SEND,  8'hF3}, '{3, 8'hFC, K_SEND,  8'hFF},
      '{4, 8'hFA, K_SEND,  8'hE8}, '{5, 8'hFE, K_SEND,  8'hE8},
      '{6, 8'hFA, K_SEND,  8'hF4}, '{6, 8'hAA, K_SEND,  8'hFF},
      '{7, 8'hFA, K_DONE,  8'h00}, '{7, 8'hFE, K_SEND,  8'hF4},
      '{7, 8'h00, K_SEND,  8'hFF}
    };

    do_reset();
    check_all_zero("reset");
    run_happy("happy");

    foreach (vt[i]) begin
      do_reset();
      pulse_start();
      walk_to(vt[i].pos, vt[i].rsp);
      if (vt[i].kind == K_SEND) begin
        wait_send($sformatf("vec%0d", i), vt[i].exp, 20);
      end else if (vt[i].kind == K_QUIET) begin
        seen = 1'b0;
        repeat (20) begin
          if (bus.send_command) seen = 1'b1;
          tick();
        end
        check($sformatf("vec%0d no send while waiting", i), 32'(seen), 0);
      end else begin
        tick();
        check($sformatf("vec%0d init_done", i), bus.init_done, 1);
      end
    end

    // Four FE replies to F3 re-send it; the fifth restarts at FF with retry=1,
    // so only three more failures are needed to reach the error state.
    do_reset();
    prefix_to(1);
    for (int k = 0; k < 5; k++) begin
      if (k > 0) wait_send("resend F3", 8'hF3, 20);
      do_sent();
      reply(8'hFE);
    end
    bad_bat_rounds("resend5", 2);

    do_reset();
    pulse_start();
    bad_bat_rounds("badbat", 3);

    // Silence after E8: the FF restart request appears 101 clocks after the
    // edge that sampled command_was_sent (decision at 100, output registered).
    do_reset();
    prefix_to(3);
    do_sent();
    n = 0;
    while (!bus.send_command && n < 200) begin
      tick();
      n++;
    end
    check("timeout cycles to FF send", n, 101);
    check("timeout restart byte", bus.the_command, 8'hFF);

    do_reset();
    prefix_to(3);
    do_sent();
    tick(99);
    reply(8'hFA);
    check("late ack send low one cycle after FA", bus.send_command, 0);
    tick();
    check("late ack send high two cycles after FA", bus.send_command, 1);
    check("late ack next byte", bus.the_command, 8'd2);

    do_reset();
    prefix_to(5);
    bus.error_communication_timed_out = 1'b1;
    bus.command_was_sent = 1'b1;
    tick();
    bus.error_communication_timed_out = 1'b0;
    bus.command_was_sent = 1'b0;
    check("txerr send_command dropped", bus.send_command, 0);
    bad_bat_rounds("txerr", 2);

    do_reset();
    pulse_start();
    wait_send("areset", 8'hFF, 20);
    #2;
    rst = 1'b1;
    #1;
    check_all_zero("async reset");
    tick();
    rst = 1'b0;
    tick();
    check_all_zero("after reset release");
    run_happy("happy after reset");

    for (int run = 0; run < 12; run++) random_run(run);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
